// File: rtl/math_adder_multiword_seq_pkg.sv
// math_adder_multiword_seq_pkg: shared types and helpers for the multiword adder sequencer
package math_adder_multiword_seq_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} mws_state_t;
  function automatic int clog2_min1(input int v);
    return ($clog2(v) > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/math_adder_multiword_seq_if.sv
// math_adder_multiword_seq_if: request/result handshake bundle of the multiword adder
interface math_adder_multiword_seq_if #(parameter int N = 32, parameter int WORDS = 4);
  localparam int W = N * WORDS;
  logic i_valid, o_ready, i_c, o_valid, i_ready, o_carry, o_busy;
  logic [W-1:0] i_a, i_b, o_sum;
  modport master (output i_valid, i_a, i_b, i_c, i_ready, input o_ready, o_valid, o_sum, o_carry, o_busy);
  modport slave (input i_valid, i_a, i_b, i_c, i_ready, output o_ready, o_valid, o_sum, o_carry, o_busy);
endinterface

// File: rtl/math_adder_brent_kung_032.sv
// math_adder_brent_kung_032: combinational N-bit Brent-Kung prefix adder with carry-in
module math_adder_brent_kung_032 #(parameter int N = 32) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c,
  output logic [N-1:0] s,
  output logic         co
);
  localparam int TOP = 1 << ($clog2(N) - 1);
  logic [N-1:0] g, p, x;
  always_comb begin
    x = a ^ b;
    g = a & b;
    p = x;
    g[0] = g[0] | (p[0] & c);
    for (int d = 1; d < N; d = d * 2)
      for (int i = 2 * d - 1; i < N; i += 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    // down-sweep fills the prefixes the up-sweep tree skipped
    for (int d = TOP; d >= 1; d = d / 2)
      for (int i = 3 * d - 1; i < N; i += 2 * d)
        g[i] = g[i] | (p[i] & g[i-d]);
    s = x ^ {g[N-2:0], c};
    co = g[N-1];
  end
endmodule

// File: rtl/math_adder_multiword_seq.sv
// math_adder_multiword_seq: W-bit addition one N-bit word per clock through a shared adder
module math_adder_multiword_seq
  import math_adder_multiword_seq_pkg::*;
#(
  parameter int N     = 32,
  parameter int WORDS = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  math_adder_multiword_seq_if.slave bus
);
  localparam int W  = N * WORDS;
  localparam int CW = clog2_min1(WORDS);
  mws_state_t state, st, state_n;
  logic [CW-1:0] cnt;
  logic [WORDS-1:0][N-1:0] a_r, b_r, sum_r;
  logic [N-1:0] s;
  logic cr, co, last, acc, valid_r, carry_r;
  math_adder_brent_kung_032 #(.N(N)) u_add (.a(a_r[cnt]), .b(b_r[cnt]), .c(cr), .s(s), .co(co));
  always_comb begin
    st = (state == ST_RUN || state == ST_DONE) ? state : ST_IDLE;
    last = cnt == CW'(WORDS - 1);
    acc = st == ST_IDLE && bus.i_valid;
    state_n = acc ? ST_RUN :
              (st == ST_RUN && last) ? ST_DONE :
              (st == ST_DONE && bus.i_ready) ? ST_IDLE : st;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      cr <= 1'b0;
      sum_r <= '0;
      carry_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        a_r <= bus.i_a;
        b_r <= bus.i_b;
        cr <= bus.i_c;
        cnt <= '0;
      end
      if (st == ST_RUN) begin
        sum_r[cnt] <= s;
        cr <= co;
        cnt <= last ? cnt : cnt + 1'b1;
        if (last) begin
          carry_r <= co;
          valid_r <= 1'b1;
        end
      end
      if (st == ST_DONE && bus.i_ready) valid_r <= 1'b0;
    end
  end
  assign bus.o_ready = st == ST_IDLE && !i_rst;
  assign bus.o_busy = st != ST_IDLE;
  assign bus.o_valid = valid_r;
  assign bus.o_carry = carry_r;
  assign bus.o_sum = W'(sum_r);
endmodule

// File: tb/tb_math_adder_multiword_seq.sv
// tb_math_adder_multiword_seq: directed and scoreboarded checks for WORDS = 2, 4, 7
module tb_math_adder_multiword_seq;
  logic clk = 1'b0;
  logic rst;
  logic [223:0] ta[3], tbv[3], osum[3];
  logic tc[3], tv[3], tr[3], ocarry[3], ovalid[3], oready[3], obusy[3];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  localparam logic [223:0] ONES128 = 224'({128{1'b1}});
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int WD = g == 0 ? 2 : g == 1 ? 4 : 7;
    math_adder_multiword_seq_if #(.N(32), .WORDS(WD)) bus ();
    assign bus.i_a = ta[g][WD*32-1:0];
    assign bus.i_b = tbv[g][WD*32-1:0];
    assign bus.i_c = tc[g];
    assign bus.i_valid = tv[g];
    assign bus.i_ready = tr[g];
    assign osum[g] = 224'(bus.o_sum);
    assign ocarry[g] = bus.o_carry;
    assign ovalid[g] = bus.o_valid;
    assign oready[g] = bus.o_ready;
    assign obusy[g] = bus.o_busy;
    math_adder_multiword_seq #(.N(32), .WORDS(WD)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  end

  task automatic op(input int k, input logic [223:0] a, input logic [223:0] b, input logic c,
                    output logic [223:0] s, output logic co, output int lat);
    ta[k] = a; tbv[k] = b; tc[k] = c; tv[k] = 1'b1; tr[k] = 1'b0;
    @(negedge clk);
    tv[k] = 1'b0;
    lat = 0;
    while (!ovalid[k] && lat < 20) begin @(negedge clk); lat++; end
    s = osum[k];
    co = ocarry[k];
  endtask

  task automatic rel(input int k);
    tr[k] = 1'b1;
    @(negedge clk);
    tr[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (oready[k] !== 1'b0 || ovalid[k] !== 1'b0 || obusy[k] !== 1'b0 || osum[k] !== '0 || ocarry[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d] ready=%b valid=%b busy=%b carry=%b sum=%h, want 0 0 0 0 0", k, oready[k], ovalid[k], obusy[k], ocarry[k], osum[k]);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (oready[1] !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", oready[1]); end
  endtask

  task automatic test_ripple;
    logic [223:0] s; logic co; int lat;
    checks++;
    if (oready[1] !== 1'b1) begin errors++; $display("FAIL ripple_ready got=%b want=1", oready[1]); end
    op(1, 224'(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF), 224'd1, 1'b0, s, co, lat);
    checks++;
    if (s !== 224'(128'h0000_0001_0000_0000_0000_0000_0000_0000) || co !== 1'b0) begin
      errors++; $display("FAIL ripple_sum got=%b_%h want=0_%h", co, s, 128'h0000_0001_0000_0000_0000_0000_0000_0000);
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL ripple_latency got=%0d want=4", lat); end
    checks++;
    if (oready[1] !== 1'b0 || obusy[1] !== 1'b1) begin errors++; $display("FAIL ripple_done_flags ready=%b busy=%b want 0 1", oready[1], obusy[1]); end
    rel(1);
    checks++;
    if (ovalid[1] !== 1'b0 || oready[1] !== 1'b1) begin errors++; $display("FAIL ripple_release valid=%b ready=%b want 0 1", ovalid[1], oready[1]); end
  endtask

  task automatic test_overflow;
    logic [223:0] s; logic co; int lat;
    op(1, ONES128, 224'd0, 1'b1, s, co, lat);
    checks++;
    if (s !== '0 || co !== 1'b1) begin errors++; $display("FAIL overflow_wrap got=%b_%h want=1_0", co, s); end
    rel(1);
    op(1, ONES128, ONES128, 1'b1, s, co, lat);
    checks++;
    if (s !== ONES128 || co !== 1'b1) begin errors++; $display("FAIL overflow_ones got=%b_%h want=1_%h", co, s, ONES128); end
    rel(1);
  endtask

  task automatic test_backpressure;
    logic [223:0] s; logic co; int lat;
    op(1, 224'd5, 224'd7, 1'b1, s, co, lat);
    checks++;
    if (s !== 224'd13 || co !== 1'b0) begin errors++; $display("FAIL bp_sum got=%b_%h want=0_d", co, s); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (ovalid[1] !== 1'b1 || osum[1] !== 224'd13 || oready[1] !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] valid=%b ready=%b sum=%h want 1 0 d", i, ovalid[1], oready[1], osum[1]);
      end
    end
    rel(1);
    checks++;
    if (ovalid[1] !== 1'b0 || oready[1] !== 1'b1) begin errors++; $display("FAIL bp_release valid=%b ready=%b want 0 1", ovalid[1], oready[1]); end
  endtask

  task automatic test_busy_ignore;
    int t;
    ta[1] = 224'(128'h00000001_00000002_00000003_00000004);
    tbv[1] = 224'(128'h10000000_20000000_30000000_40000000);
    tc[1] = 1'b0; tv[1] = 1'b1; tr[1] = 1'b0;
    @(negedge clk);
    ta[1] = ONES128; tbv[1] = ONES128; tc[1] = 1'b1;
    t = 0;
    while (!ovalid[1] && t < 20) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    checks++;
    if (osum[1] !== 224'(128'h10000001_20000002_30000003_40000004) || ocarry[1] !== 1'b0 || ovalid[1] !== 1'b1) begin
      errors++; $display("FAIL busy_ignore valid=%b got=%b_%h want=0_%h", ovalid[1], ocarry[1], osum[1], 128'h10000001_20000002_30000003_40000004);
    end
    tv[1] = 1'b0;
    rel(1);
    checks++;
    if (obusy[1] !== 1'b0) begin errors++; $display("FAIL busy_idle got=%b want=0", obusy[1]); end
  endtask

  task automatic test_reset_mid_run;
    logic [223:0] s; logic co; int lat;
    ta[1] = ONES128; tbv[1] = ONES128; tc[1] = 1'b1; tv[1] = 1'b1;
    @(negedge clk);
    tv[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ovalid[1] !== 1'b0 || osum[1] !== '0 || ocarry[1] !== 1'b0 || obusy[1] !== 1'b0 || oready[1] !== 1'b0) begin
      errors++; $display("FAIL midrst valid=%b busy=%b ready=%b carry=%b sum=%h want all 0", ovalid[1], obusy[1], oready[1], ocarry[1], osum[1]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (oready[1] !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", oready[1]); end
    op(1, 224'(128'h89ABCDEF_01234567_FFFFFFFF_80000000), 224'(128'h76543210_FEDCBA98_00000000_80000000), 1'b1, s, co, lat);
    checks++;
    if (s !== 224'd1 || co !== 1'b1 || lat !== 4) begin errors++; $display("FAIL midrst_next got=%b_%h lat=%0d want=1_1 lat=4", co, s, lat); end
    rel(1);
  endtask

  task automatic test_random(input int k, input int words, input int nops);
    logic [223:0] a, b;
    logic [224:0] e, m;
    logic c;
    int t, r, tacc, pacc, stall, pstall;
    m = (225'(1) << (words * 32)) - 225'(1);
    pstall = 1; pacc = 0;
    tv[k] = 1'b1; tr[k] = 1'b0;
    for (int n = 0; n < nops; n++) begin
      for (int j = 0; j < 7; j++) begin a[j*32 +: 32] = $urandom; b[j*32 +: 32] = $urandom; end
      r = $urandom_range(0, 7);
      if (r == 0) a = '1;
      if (r == 1) b = '1;
      if (r == 2) b = '0;
      c = 1'($urandom_range(0, 1));
      ta[k] = a; tbv[k] = b; tc[k] = c;
      t = 0;
      while (!oready[k] && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      tacc = cyc;
      if (pstall == 0) begin
        checks++;
        if (tacc - pacc !== words + 2) begin errors++; $display("FAIL rand_period[w%0d] got=%0d want=%0d", words, tacc - pacc, words + 2); end
      end
      t = 0;
      while (!ovalid[k] && t < 100) begin @(negedge clk); t++; end
      e = (225'(a) & m) + (225'(b) & m) + 225'(c);
      checks++;
      if (osum[k] !== (e[223:0] & m[223:0]) || ocarry[k] !== e[words*32] || t !== words) begin
        errors++;
        $display("FAIL rand_sum[w%0d #%0d] got=%b_%h lat=%0d want=%b_%h lat=%0d", words, n, ocarry[k], osum[k], t, e[words*32], e[223:0] & m[223:0], words);
      end
      stall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      repeat (stall) @(negedge clk);
      rel(k);
      pacc = tacc; pstall = stall;
    end
    tv[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ta[k] = '0; tbv[k] = '0; tc[k] = 1'b0; tv[k] = 1'b0; tr[k] = 1'b0;
    end
    test_reset;
    test_ripple;
    test_overflow;
    test_backpressure;
    test_busy_ignore;
    test_reset_mid_run;
    test_random(0, 2, 1000);
    test_random(1, 4, 2000);
    test_random(2, 7, 1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
